// File: rtl/keyed_sec_pipe.sv
// keyed_sec_pipe
//   Two-stage SEC (single-error-correct) decode pipeline whose output is XOR-gated by a
//   serially loaded key. Stage 1 registers the data word and its syndrome. Stage 2
//   corrects the word, flags corrected or uncorrectable errors and applies the key.
//   A correct key (key_x == KEY_MASK) yields plain corrected data. With no key loaded,
//   the output is scrambled by KEY_MASK.
//
// Optional feature (compile-time macro KEYED_SEC_MUX_LOCK_EN):
//   Syndrome bit 0 is routed through a 4-entry key-driven lookup, p[2*S[0]+S[1]].
//   p holds the last 4 key bits shifted in. The key gains 4 bits (KEY_W = DATA_W + 4).
//   p = 4'b1100 makes the lookup an identity.
//   With the macro undefined, S[0] is used directly and KEY_W = DATA_W.
//
// Ports
//   CK, RST            clock; synchronous active-high reset
//   in_valid/in_ready  input handshake; in_data (DATA_W), in_chk (CHK_W)
//   out_valid/out_ready output handshake; out_data (DATA_W), out_corr, out_unc
//   key_in, key_shift  serial key bit (MSB first) and its shift strobe
//   key_rdy            pipeline empty, a key load may start
//   key_loaded         a complete key has been applied (state ACTIVE)

module keyed_sec_pipe #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       CHK_W    = 7,
    parameter logic [DATA_W-1:0] KEY_MASK = DATA_W'(32'hA5A5_5A5A)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_unc,
    input  logic              key_in,
    input  logic              key_shift,
    output logic              key_rdy,
    output logic              key_loaded
);

`ifdef KEYED_SEC_MUX_LOCK_EN
    localparam int unsigned KEY_W = DATA_W + 4;
`else
    localparam int unsigned KEY_W = DATA_W;
`endif
    localparam int unsigned CNT_W = $clog2(KEY_W + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Column j of H is the j-th ascending CHK_W-bit value with at least two set bits,
    // so columns never collide with the single-bit syndromes of check-bit errors.
    function automatic logic [DATA_W*CHK_W-1:0] build_cols();
        logic [DATA_W*CHK_W-1:0] t;
        int unsigned             n;
        int unsigned             pc;
        t = '0;
        n = 0;
        for (int unsigned v = 0; v < (32'd1 << CHK_W); v++) begin
            pc = 0;
            for (int unsigned b = 0; b < CHK_W; b++) begin
                pc = pc + ((v >> b) & 32'd1);
            end
            if (pc >= 2 && n < DATA_W) begin
                t[n*CHK_W +: CHK_W] = CHK_W'(v);
                n = n + 1;
            end
        end
        return t;
    endfunction

    localparam logic [DATA_W*CHK_W-1:0] H_COLS = build_cols();

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [KEY_W-1:0]  r_key_sh;
    logic [KEY_W-1:0]  r_key_app;

    logic              r_s1_full;
    logic [DATA_W-1:0] r_s1_data;
    logic [CHK_W-1:0]  r_s1_syn;

    logic              r_s2_full;
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_corr;
    logic              r_s2_unc;

    // ------------------------------------------------------------------
    // Key load control
    // ------------------------------------------------------------------
    logic              w_pipe_empty;
    logic              w_start;
    logic              w_shift;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_done;
    logic [KEY_W-1:0]  w_key_sh_nxt;
    logic [DATA_W-1:0] w_key_x;

    assign w_pipe_empty = ~r_s1_full & ~r_s2_full;
    // A load may only begin with nothing in flight, so the applied key is constant for
    // every word inside the pipeline.
    assign w_start      = key_shift & w_pipe_empty & (r_state != ST_LOAD);
    assign w_shift      = w_start | (key_shift & (r_state == ST_LOAD));
    assign w_cnt_nxt    = w_start ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_done       = w_shift & (w_cnt_nxt == CNT_W'(KEY_W));
    assign w_key_sh_nxt = KEY_W'({r_key_sh, key_in});
    assign w_key_x      = r_key_app[KEY_W-1 -: DATA_W];

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_key_sh  <= '0;
            r_key_app <= '0;
        end else if (w_shift) begin
            r_key_sh <= w_key_sh_nxt;
            if (w_done) begin
                r_state   <= ST_ACTIVE;
                r_cnt     <= '0;
                r_key_app <= w_key_sh_nxt;
            end else begin
                r_state <= ST_LOAD;
                r_cnt   <= w_cnt_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline handshake
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_in_ready;
    logic w_accept;

    assign w_s2_adv   = r_s1_full & (~r_s2_full | out_ready);
    // The cycle that starts a key load also blocks input so the pipe stays empty.
    assign w_in_ready = ~RST & (r_state != ST_LOAD) & ~w_start & (~r_s1_full | w_s2_adv);
    assign w_accept   = in_valid & w_in_ready;

    // ------------------------------------------------------------------
    // Stage 1: syndrome
    // ------------------------------------------------------------------
    logic [CHK_W-1:0] w_syn;

    always_comb begin
        w_syn = in_chk;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            if (in_data[j]) begin
                w_syn = w_syn ^ H_COLS[j*CHK_W +: CHK_W];
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_s1_full <= 1'b0;
            r_s1_data <= '0;
            r_s1_syn  <= '0;
        end else if (w_accept) begin
            r_s1_full <= 1'b1;
            r_s1_data <= in_data;
            r_s1_syn  <= w_syn;
        end else if (w_s2_adv) begin
            r_s1_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: correct, classify, key-gate
    // ------------------------------------------------------------------
    logic [CHK_W-1:0]  w_syn_eff;
    logic [DATA_W-1:0] w_fix_data;
    logic [DATA_W-1:0] w_dec_data;
    logic              w_hit;
    logic              w_dec_corr;
    logic              w_dec_unc;

`ifdef KEYED_SEC_MUX_LOCK_EN
    logic [3:0] w_key_p;
    assign w_key_p = r_key_app[3:0];
`endif

    always_comb begin
        w_syn_eff = r_s1_syn;
`ifdef KEYED_SEC_MUX_LOCK_EN
        // Index is 2*S[0] + S[1]; only p = 4'b1100 passes S[0] through unchanged.
        w_syn_eff[0] = w_key_p[{r_s1_syn[0], r_s1_syn[1]}];
`endif
        w_fix_data = r_s1_data;
        w_hit      = 1'b0;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            if (w_syn_eff == H_COLS[j*CHK_W +: CHK_W]) begin
                w_fix_data[j] = ~r_s1_data[j];
                w_hit         = 1'b1;
            end
        end
        w_dec_corr = 1'b0;
        w_dec_unc  = 1'b0;
        if (w_syn_eff == '0) begin
            w_dec_corr = 1'b0;
        end else if (w_hit) begin
            w_dec_corr = 1'b1;
        end else if ((w_syn_eff & (w_syn_eff - CHK_W'(1))) == '0) begin
            // Single check-bit error: data is already correct.
            w_dec_corr = 1'b1;
        end else begin
            w_dec_unc = 1'b1;
        end
        w_dec_data = w_fix_data ^ w_key_x ^ KEY_MASK;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_s2_full <= 1'b0;
            r_s2_data <= '0;
            r_s2_corr <= 1'b0;
            r_s2_unc  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_full <= 1'b1;
            r_s2_data <= w_dec_data;
            r_s2_corr <= w_dec_corr;
            r_s2_unc  <= w_dec_unc;
        end else if (out_ready) begin
            r_s2_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (forced quiet while reset is asserted)
    // ------------------------------------------------------------------
    assign in_ready   = w_in_ready;
    assign out_valid  = ~RST & r_s2_full;
    assign out_data   = RST ? '0 : r_s2_data;
    assign out_corr   = ~RST & r_s2_corr;
    assign out_unc    = ~RST & r_s2_unc;
    assign key_rdy    = RST | w_pipe_empty;
    assign key_loaded = ~RST & (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_keyed_sec_pipe.sv
module tb_keyed_sec_pipe;

    localparam int          DW   = 32;
    localparam int          CW   = 7;
    localparam logic [31:0] MASK = 32'hA5A5_5A5A;
`ifdef KEYED_SEC_MUX_LOCK_EN
    localparam int KW   = DW + 4;
    localparam bit LOCK = 1'b1;
`else
    localparam int KW   = DW;
    localparam bit LOCK = 1'b0;
`endif

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_chk = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_corr;
    logic          out_unc;
    logic          key_in = 1'b0;
    logic          key_shift = 1'b0;
    logic          key_rdy;
    logic          key_loaded;

    always #5 CK = ~CK;

    keyed_sec_pipe dut (
        .CK        (CK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_chk    (in_chk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_corr  (out_corr),
        .out_unc   (out_unc),
        .key_in    (key_in),
        .key_shift (key_shift),
        .key_rdy   (key_rdy),
        .key_loaded(key_loaded)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_key = '0;   // applied DATA_W key
    logic [3:0]  m_p   = '0;   // lock bits
    int          m_state = 0;  // 0 idle, 1 load, 2 active

    function automatic logic [6:0] mcol(input int j);
        int n = 0;
        for (int v = 0; v < 128; v++) begin
            if ($countones(v[6:0]) >= 2) begin
                if (n == j) return v[6:0];
                n++;
            end
        end
        return '0;
    endfunction

    // Check bits that make the syndrome zero for d.
    function automatic logic [6:0] good_chk(input logic [31:0] d);
        logic [6:0] c = '0;
        for (int j = 0; j < 32; j++) if (d[j]) c ^= mcol(j);
        return c;
    endfunction

    // Returns {corr, unc, out_data}.
    function automatic logic [33:0] model(input logic [31:0] d, input logic [6:0] c,
                                         input logic [31:0] kx, input logic [3:0] kp);
        logic [6:0]  s;
        logic [31:0] o;
        bit          hit;
        int          idx;
        s = c;
        for (int j = 0; j < 32; j++) if (d[j]) s ^= mcol(j);
        if (LOCK) begin
            idx  = 2 * int'(s[0]) + int'(s[1]);
            s[0] = kp[idx];
        end
        o   = d;
        hit = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (s != 0 && mcol(j) == s) begin
                o[j] = ~o[j];
                hit  = 1'b1;
            end
        end
        return {(s != 0) && (hit || $countones(s) == 1),
                (s != 0) && !hit && ($countones(s) != 1),
                o ^ kx ^ MASK};
    endfunction

    // ---------------- compare process ----------------
    logic [33:0] q[$];
    bit          stall_prev = 1'b0;
    logic [33:0] prev_out;
    logic [33:0] exp_w;

    always @(negedge CK) begin
        if (RST) begin
            q.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_data", out_data, 0);
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {out_valid, out_corr, out_unc, out_data}, {1'b1, prev_out});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else if (out_ready) begin
                    exp_w = q.pop_front();
                    chk("out_word", {out_corr, out_unc, out_data}, exp_w);
                end
            end
            if (q.size() >= 2 && out_valid && !out_ready) chk("in_ready_full", in_ready, 0);
            chk("key_loaded", key_loaded, (m_state == 2));
            if (in_valid && in_ready) q.push_back(model(in_data, in_chk, m_key, m_p));
            stall_prev = out_valid & ~out_ready;
            prev_out   = {out_corr, out_unc, out_data};
        end
    end

    // ---------------- stimulus tasks (called at #1 after a rising edge) ----------------
    task automatic send_word(input logic [31:0] d, input logic [6:0] c);
        int n = 0;
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        in_chk   = c;
        do begin
            @(negedge CK);
            acc = in_ready;
            @(posedge CK);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            @(posedge CK);
            n++;
        end
        #1;
        chk("drain", q.size(), 0);
    endtask

    // Single word with an exact 2-cycle latency and a literal expected result.
    task automatic send_one(input string name, input logic [31:0] d, input logic [6:0] c,
                            input logic [31:0] ed, input logic ec, input logic eu);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_chk    = c;
        @(negedge CK);
        chk({name, "_acc"}, in_ready, 1);
        @(posedge CK);
        #1;
        in_valid = 1'b0;
        chk({name, "_lat1"}, out_valid, 0);
        @(posedge CK);
        #1;
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data, ed);
        chk({name, "_corr"}, out_corr, ec);
        chk({name, "_unc"}, out_unc, eu);
        @(posedge CK);
        #1;
    endtask

    // Shift nbits of {kx, kp} (MSB first); a full load commits the model key.
    task automatic load_key(input logic [31:0] kx, input logic [3:0] kp, input int nbits);
        logic [35:0] full;
        full = {kx, kp};
        for (int i = 0; i < nbits; i++) begin
            key_in    = full[35-i];
            key_shift = 1'b1;
            @(posedge CK);
            #1;
            m_state = 1;
            if (i == 0) chk("load_in_ready", in_ready, 0);
        end
        key_shift = 1'b0;
        if (nbits == KW) begin
            m_state = 2;
            m_key   = kx;
            m_p     = LOCK ? kp : 4'b0000;
            chk("load_done", key_loaded, 1);
        end
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        m_state = 0;
        m_key   = '0;
        m_p     = '0;
        repeat (2) @(posedge CK);
        #1;
        RST = 1'b0;
        #1;
    endtask

    logic [31:0] sd[8];
    logic [6:0]  sc[8];
    int          quiet;

    initial begin
        // Reset state
        repeat (3) @(posedge CK);
        #1;
        chk("rst_key_rdy", key_rdy, 1);
        chk("rst_key_loaded", key_loaded, 0);
        RST = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_out_data", out_data, 0);
        chk("post_rst_flags", {out_corr, out_unc}, 0);
        chk("post_rst_key_rdy", key_rdy, 1);
        @(posedge CK);
        #1;

        // IDLE: locked output
        send_one("idle_locked", 32'h0, 7'h00, 32'hA5A5_5A5A, 1'b0, 1'b0);
        send_word(32'h0000_0001, 7'h00);
        send_word(32'hFFFF_FFFF, good_chk(32'hFFFF_FFFF));
        drain();

        // Correct key
        load_key(MASK, 4'b1100, KW);
        send_one("zero", 32'h0, 7'h00, 32'h0, 1'b0, 1'b0);
        send_one("bit0_err", 32'h1, 7'h00, 32'h0, 1'b1, 1'b0);
        send_one("chk_err", 32'h0, 7'h40, 32'h0, 1'b1, 1'b0);
        send_one("uncorr", 32'h0, 7'h7F, 32'h0, 1'b0, 1'b1);

        // Stream of 8 words with a 3-cycle output stall
        sd = '{32'h0000_00FF, 32'hDEAD_BEEF ^ 32'h20, 32'h8000_0000, 32'h1234_5678 ^ 32'h3,
               32'hCAFE_F00D, 32'h0F0F_0F0F, 32'h0000_0000, 32'hFFFF_FFFF ^ 32'h8000_0000};
        sc = '{good_chk(32'h0000_00FF), good_chk(32'hDEAD_BEEF),
               good_chk(32'h8000_0000) ^ 7'h08, good_chk(32'h1234_5678),
               good_chk(32'hCAFE_F00D), 7'h7F, 7'h01, good_chk(32'hFFFF_FFFF)};
        fork
            begin
                for (int i = 0; i < 8; i++) send_word(sd[i], sc[i]);
            end
            begin
                repeat (4) @(posedge CK);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge CK);
                #1;
                chk("stall_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        drain();

        // key_shift while words are in flight is ignored
        out_ready = 1'b0;
        send_word(32'h0000_0055, good_chk(32'h0000_0055));
        @(posedge CK);
        #1;
        chk("key_rdy_busy", key_rdy, 0);
        key_in    = 1'b1;
        key_shift = 1'b1;
        @(posedge CK);
        #1;
        key_shift = 1'b0;
        chk("shift_ignored", key_loaded, 1);
        drain();

        // Different key, then a mid-load reset
        load_key(32'h1234_5678, 4'b1100, KW);
        send_one("key2", 32'h0, 7'h00, 32'hB791_0C22, 1'b0, 1'b0);
        send_word(32'h0000_0010, good_chk(32'h0000_0010) ^ 7'h02);
        drain();
        load_key(MASK, 4'b1100, 10);
        do_reset();
        chk("midload_key_loaded", key_loaded, 0);
        send_one("after_midload", 32'h0, 7'h00, 32'hA5A5_5A5A, 1'b0, 1'b0);

        // Mid-stream reset discards words in flight
        load_key(MASK, 4'b1100, KW);
        out_ready = 1'b0;
        send_word(32'h1, 7'h0);
        send_word(32'h2, 7'h0);
        do_reset();
        out_ready = 1'b1;
        quiet = 0;
        repeat (5) begin
            @(negedge CK);
            if (out_valid) quiet++;
        end
        chk("post_rst_quiet", quiet, 0);
        @(posedge CK);
        #1;
        send_word(32'h0000_0003, 7'h00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keyed_sec_pipe.md
KEYED_SEC_PIPE -- requirements
Module: keyed_sec_pipe

Interface
REQ-001 Parameter DATA_W, default 32: data word width, 1..57.
REQ-002 Parameter CHK_W, default 7: check/syndrome width; 2^CHK_W-1-CHK_W >= DATA_W.
REQ-003 Parameter KEY_MASK, default 32'hA5A5_5A5A, DATA_W bits: correct output-key value.
REQ-004 CK  in  1  clock; all state changes on rising edge; one clock domain.
REQ-005 RST  in  1  reset; synchronous, active-high.
REQ-006 in_valid  in  1  input word valid.
REQ-007 in_ready  out  1  input accepted when in_valid & in_ready.
REQ-008 in_data  in  DATA_W  received data bits.
REQ-009 in_chk  in  CHK_W  received check bits.
REQ-010 out_valid  out  1  output word valid.
REQ-011 out_ready  in  1  consumer accepts when out_valid & out_ready.
REQ-012 out_data  out  DATA_W  corrected, key-gated data.
REQ-013 out_corr  out  1  single error corrected (data or check bit).
REQ-014 out_unc  out  1  nonzero syndrome matching no column; data passed uncorrected.
REQ-015 key_in  in  1  serial key bit, MSB first.
REQ-016 key_shift  in  1  shift key_in into key shift register this cycle.
REQ-017 key_rdy  out  1  high when both pipeline stages are empty.
REQ-018 key_loaded  out  1  high in state ACTIVE.

Function
REQ-019 H column of data bit j: j-th value, ascending, of CHK_W-bit integers with popcount >= 2 (bit0=3, bit1=5, bit2=6, bit3=7, bit4=9).
REQ-020 Stage 1 registers syndrome S = in_chk XOR (XOR of H columns of all set in_data bits), plus the data.
REQ-021 Stage 2: S==0 -> no flip; S equals column j -> flip bit j, out_corr=1; S power of two -> no flip, out_corr=1; otherwise no flip, out_unc=1.
REQ-022 out_data = corrected data XOR key_x XOR KEY_MASK; key_x is the applied DATA_W-bit key.
REQ-023 Latency: exactly 2 cycles from accept to out_valid with no backpressure; throughput 1 word/cycle.
REQ-024 Handshake: stage advances when downstream is empty or being drained; out_valid & ~out_ready holds all outputs stable; in_ready = ~stage1_full | stage1_advances, forced 0 in LOAD.
REQ-025 FSM states IDLE, LOAD, ACTIVE; IDLE -> LOAD and ACTIVE -> LOAD on key_shift & key_rdy; LOAD -> ACTIVE on the KEY_W-th shift.
REQ-026 KEY_W = DATA_W (+4 with MUX_LOCK_EN); key_shift while key_rdy=0 outside LOAD is ignored.
REQ-027 Applied key registers update atomically on LOAD -> ACTIVE; the shift register alone changes during LOAD.
REQ-028 key_shift held in LOAD beyond KEY_W shifts: extra shifts start a new load (stay LOAD, count restarts at 1).
REQ-029 IDLE processes data with applied key all zero (locked output).

Reset
REQ-030 RST: state IDLE, shift count 0, shift/applied keys 0, both stages empty.
REQ-031 During and after RST: out_valid=0, out_corr=0, out_unc=0, out_data=0, in_ready=0 during reset, 1 the cycle after, key_rdy=1, key_loaded=0.
REQ-032 RST mid-load or mid-stream discards partial key and in-flight words; no output produced.

Configuration
REQ-033 Macro KEYED_SEC_MUX_LOCK_EN defined: syndrome bit 0 replaced by p[2*S[0]+S[1]], p = 4 key bits shifted last; correct p = 4'b1100.
REQ-034 Macro undefined: S[0] used directly, KEY_W = DATA_W, no LUT logic.

Verification (DATA_W=32, CHK_W=7, macro defined, correct key = KEY_MASK then 4'b1100)
REQ-035 Load correct key, data 0x0000_0000 chk 0x00 -> 2 cycles later out_data 0x0000_0000, corr=0, unc=0.
REQ-036 Correct key, data 0x0000_0001 chk 0x00 -> S=3, out_data 0x0000_0000, out_corr=1.
REQ-037 Correct key, data 0 chk 0x40 -> out_data 0, out_corr=1; data 0 chk 0x7F -> out_data 0, out_unc=1.
REQ-038 No key loaded (IDLE), data 0 chk 0 -> out_data 0xA5A5_5A5A.
REQ-039 Stream 8 words, out_ready low 3 cycles mid-stream -> no loss/duplication, outputs stable while stalled, in_ready low when both stages full.
REQ-040 RST after 10 of 36 key shifts -> key_loaded=0, next word output equals IDLE (locked) result.
